// File: rtl/palindrome_pkg.sv
// Shared definitions for the palindrome generator and its checker benches.
//   state_t  : generator FSM states (IDLE, SEND)
//   half_w() : seed width for a given palindrome width, (width+1)/2
//   mirror() : reference palindrome builder. The seed is LSB-aligned in a
//              MAX_W-bit vector and the result is LSB-aligned as well.
package palindrome_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int MAX_W = 64;

  function automatic int half_w(input int width);
    return (width + 1) / 2;
  endfunction

  // The seed fills the upper half of the word. Each lower bit then copies
  // the bit it faces across the centre. Bits at or above width stay zero.
  function automatic logic [MAX_W-1:0] mirror(input logic [MAX_W-1:0] seed,
                                              input int width);
    logic [MAX_W-1:0] p;
    int h;
    p = '0;
    h = half_w(width);
    for (int i = 0; i < MAX_W; i++) begin
      if (i < h) p[width-h+i] = seed[i];
    end
    for (int i = 0; i < MAX_W; i++) begin
      if (i < width - h) p[i] = p[width-1-i];
    end
    return p;
  endfunction

endpackage

// File: rtl/palindrome_gen_if.sv
// Seed-in / serial-out bus of the palindrome generator.
//   din, din_valid, din_ready          : seed handshake (HALF_W-bit seed)
//   dout, dout_valid, dout_ready       : serial bit handshake, MSB first
//   dout_last                          : current bit is the final bit, P[0]
//   dout_word                          : full palindrome of the word in flight
// The slave modport is the generator. The master modport is its environment.
interface palindrome_gen_if #(
  parameter int DATA_WIDTH = 32
) ();
  localparam int HALF_W = palindrome_pkg::half_w(DATA_WIDTH);

  logic [HALF_W-1:0]     din;
  logic                  din_valid;
  logic                  din_ready;
  logic                  dout;
  logic                  dout_valid;
  logic                  dout_ready;
  logic                  dout_last;
  logic [DATA_WIDTH-1:0] dout_word;

  modport slave (
    input  din, din_valid, dout_ready,
    output din_ready, dout, dout_valid, dout_last, dout_word
  );

  modport master (
    output din, din_valid, dout_ready,
    input  din_ready, dout, dout_valid, dout_last, dout_word
  );
endinterface

// File: rtl/palindrome_mirror.sv
// Combinational palindrome builder.
//   seed : HALF_W-bit seed. It becomes the upper HALF_W bits of the word.
//   word : DATA_WIDTH-bit palindrome. For odd widths the middle bit is seed[0].
module palindrome_mirror
  import palindrome_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  localparam int HALF_W    = half_w(DATA_WIDTH)
) (
  input  logic [HALF_W-1:0]     seed,
  output logic [DATA_WIDTH-1:0] word
);

  localparam int LOW_W = DATA_WIDTH - HALF_W;

  // The lower bits take the seed in reversed order, so word[0] = seed[MSB].
  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
    if (i >= LOW_W) begin : g_upper
      assign word[i] = seed[i-LOW_W];
    end else begin : g_lower
      assign word[i] = seed[HALF_W-1-i];
    end
  end

endmodule

// File: rtl/palindrome_gen.sv
// Bit-serial palindrome generator.
// It accepts a half-width seed, builds the DATA_WIDTH-bit palindrome and
// shifts it out MSB first under valid/ready flow control. The full word is
// presented in parallel on dout_word until the next load.
//   clk   : rising-edge clock
//   reset : synchronous, active-high. It abandons any word in flight.
//   bus   : palindrome_gen_if.slave (seed handshake in, serial stream out)
// A seed offered on the cycle the last bit transfers is loaded at once, so
// consecutive words stream with no bubble.
module palindrome_gen
  import palindrome_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  palindrome_gen_if.slave  bus
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DATA_WIDTH - 1);

  state_t                state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] word_q;
  logic [DATA_WIDTH-1:0] word_next;
  logic [CNT_W-1:0]      cnt;
  logic                  at_last;
  logic                  xfer;
  logic                  load;

  palindrome_mirror #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mirror (
    .seed (bus.din),
    .word (word_next)
  );

  assign at_last        = (cnt == '0);
  assign bus.dout_valid = (state == SEND);
  assign bus.dout_last  = bus.dout_valid & at_last;
  assign bus.dout       = shreg[DATA_WIDTH-1];
  assign bus.dout_word  = word_q;

  // Ready opens on the last transfer as well as in IDLE. This is what
  // allows back-to-back words.
  assign xfer          = bus.dout_valid & bus.dout_ready;
  assign bus.din_ready = (state == IDLE) | (xfer & at_last);
  assign load          = bus.din_valid & bus.din_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      shreg  <= '0;
      word_q <= '0;
      cnt    <= '0;
    end else if (load) begin
      state  <= SEND;
      shreg  <= word_next;
      word_q <= word_next;
      cnt    <= CNT_TOP;
    end else if (xfer) begin
      if (at_last) begin
        state <= IDLE;
      end else begin
        shreg <= {shreg[DATA_WIDTH-2:0], 1'b0};
        cnt   <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: doc/palindrome_gen.md
Name: palindrome_gen

Overview:
- Transmit-side counterpart of the team's palindrome checker: builds a DATA_WIDTH-bit binary palindrome from a half-width seed, then streams it out bit-serially, MSB first, under valid/ready flow control.
- Also presents the full palindrome in parallel for the whole transfer.
- Feeds serial links and checker benches that expect palindromic words, including leading zeros.

Parameters:
- DATA_WIDTH, 32, width of the generated palindrome; must be >= 2; odd values are legal.
- HALF_W, (DATA_WIDTH+1)/2, seed width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- din  input  HALF_W  seed; becomes the upper HALF_W bits of the palindrome.
- din_valid  input  1  seed available.
- din_ready  output  1  seed accepted this cycle when din_valid & din_ready.
- dout  output  1  current serial bit.
- dout_valid  output  1  dout holds a valid bit.
- dout_ready  input  1  consumer takes the bit when dout_valid & dout_ready.
- dout_last  output  1  current bit is P[0], the final bit of the word.
- dout_word  output  DATA_WIDTH  full palindrome being sent; held until the next load.

Behaviour:
- Word construction:
  - P[DATA_WIDTH-1 -: HALF_W] = din.
  - P[i] = P[DATA_WIDTH-1-i] for i < DATA_WIDTH-HALF_W.
  - For odd widths the middle bit is din[0].
- States:
  - IDLE: dout_valid=0.
  - SEND: dout_valid=1.
- Reset values: state IDLE, dout=0, dout_valid=0, dout_last=0, dout_word=0, bit counter=0. Reset wins over every other event in the same cycle.
- din_ready is combinational: din_ready = (state==IDLE) | (dout_valid & dout_ready & dout_last).
- Load (din_valid & din_ready):
  - Register P into dout_word and the shift register.
  - Set counter = DATA_WIDTH-1.
  - Go to SEND.
  - dout = P[DATA_WIDTH-1] and dout_valid=1 from the next cycle. Latency is 1 cycle from acceptance to the first bit.
- In SEND, each transfer (dout_valid & dout_ready) advances to the next lower bit and decrements the counter.
- dout_last = dout_valid & (counter==0).
- Stall (dout_ready=0): dout, dout_last, dout_word and counter hold, and dout_valid stays 1. Asserting valid does not depend on ready.
- Transfer of the last bit:
  - With din_valid=1 the same cycle, load the new seed and stay in SEND. This is back-to-back with no bubble, so throughput is DATA_WIDTH cycles per word.
  - Otherwise return to IDLE with dout_valid=0.
- A din_valid in SEND before the last-bit transfer is not accepted (din_ready=0), and din must stay stable.
- Reset mid-word abandons the word. There is no partial resumption, and dout_valid drops the cycle after reset is sampled.
- Counter width: $clog2(DATA_WIDTH). Wrap below 0 is impossible because the last transfer reloads or leaves SEND.

Decomposition:
- Shared package palindrome_pkg holds:
  - the state enum {IDLE, SEND}
  - the function half_w(width)
  - the function mirror(seed, width) returning P
- The package is reused by the checker bench for its reference model.
- One natural combinational sub-module, palindrome_mirror (seed in, DATA_WIDTH word out), instantiated at the load path.

Test Plan:
- DATA_WIDTH=8, din=4'b1011, dout_ready=1:
  - dout_word=8'b10111101.
  - Serial bits 1,0,1,1,1,1,0,1 on 8 consecutive cycles starting 1 cycle after accept.
  - dout_last only on the 8th bit.
- DATA_WIDTH=5, din=3'b110:
  - dout_word=5'b11011.
  - 5 bits, then IDLE with din_ready=1.
- Back-to-back, DATA_WIDTH=8, din_valid held with 8'hA then 8'h3 seeds (4-bit 1010, 0011):
  - second accept coincides with the first word's last transfer.
  - bits of 10100101 then 00111100 with no gap.
- Backpressure: dout_ready toggled 1,0,0,1 during a word:
  - dout and counter hold on stalled cycles.
  - total of DATA_WIDTH transfers, and the bit sequence is unchanged.
- Reset asserted after 3 bits of din=4'b1011:
  - next cycle dout_valid=0, dout_word=0, din_ready=1.
  - a fresh seed restarts from P[7].
- din=0 at DATA_WIDTH=32:
  - 32 zero bits streamed, covering leading zeros.
  - the checker model reports palindrome=1.
